world_seeder: RTL and testbench
===============================

Name: world_seeder

Overview:
- Builds the initial world state for the ant simulation. It sits directly downstream of the 32-bit LFSR random source and drives that source's seed load.
- On start it seeds the LFSR from the NIOS-II supplied seed, then clears the grid RAM and writes the nest.
- It then places NUM_FOOD food piles and NUM_ANTS ants at random empty cells, using rejection sampling.
- It reports done or error back to the NIOS-II.

Parameters:
- X_BITS, 6: grid x coordinate width; grid width = 2**X_BITS.
- Y_BITS, 6: grid y coordinate width; grid height = 2**Y_BITS.
- NUM_FOOD, 16: number of food piles to place (>=1).
- NUM_ANTS, 8: number of ants to place (>=1).
- STRIDE, 32: LFSR cycles waited between draws, so every draw uses fully fresh bits (>=1).
- MAX_RETRY, 255: consecutive occupied-cell draws allowed for one item before abort.

Ports:
- rand_clk  in  1  sole clock; same clock as the LFSR.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to build a world.
- seed  in  32  seed from the NIOS-II, sampled on start.
- rand_value  in  32  current LFSR output.
- ld_seed  out  1  LFSR load strobe.
- rand_seed  out  32  value loaded into the LFSR.
- mem_addr  out  X_BITS+Y_BITS  grid RAM address, {y,x}.
- mem_wdata  out  8  cell write data.
- mem_we  out  1  grid RAM write enable.
- mem_rdata  in  8  grid RAM read data; valid exactly 1 cycle after mem_addr is presented.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  level; high after successful completion until the next accepted start.
- error  out  1  level; high after a retry abort until the next accepted start.

Behaviour:
- Clock and reset: one clock, rand_clk. Reset is synchronous and active-low on reset_n.
- Reset values: state=IDLE; ld_seed=0, rand_seed=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, error=0. Internal counters are 0.
- Reset mid-operation: in the next cycle the block returns to IDLE with mem_we=0. Grid contents are left as-is.
- Cell encoding: [7:6] type (00 empty, 01 food, 10 ant, 11 nest); [5:0] payload.
  - Food payload = amount.
  - Ant payload = 6'b0 (heading / state reserved).
  - Nest payload = 6'b0.
- IDLE:
  - start=1 is accepted: clear done/error, go to SEED.
  - start while not IDLE is ignored.
- SEED (1 cycle):
  - ld_seed=1; rand_seed=seed.
  - If seed==32'hFFFF_FFFF (XNOR-LFSR lock-up), rand_seed=32'hFFFF_FFFE instead.
  - Go to CLEAR.
- CLEAR:
  - One write per cycle, mem_we=1, mem_wdata=8'h00.
  - mem_addr counts 0 .. 2**(X_BITS+Y_BITS)-1, then go to NEST.
- NEST (1 cycle):
  - Write 8'hC0 at x=2**(X_BITS-1), y=2**(Y_BITS-1).
  - Reset item index and retry count; go to WAIT.
- WAIT: count STRIDE cycles, then go to DRAW.
- DRAW (1 cycle):
  - Latch x=rand_value[X_BITS-1:0], y=rand_value[X_BITS+Y_BITS-1:X_BITS].
  - Latch amt=rand_value[31:26] | 6'd1 (never 0).
  - Drive mem_addr={y,x}; mem_we=0; go to CHECK.
- CHECK (1 cycle, mem_rdata valid):
  - If mem_rdata[7:6]==00: go to WRITE and clear the retry count.
  - Otherwise: increment the retry count. If it reaches MAX_RETRY, set error=1 and go to DONE; else go to WAIT.
- WRITE (1 cycle):
  - mem_we=1 at the same address.
  - Data = {2'b01,amt} while item < NUM_FOOD, else {2'b10,6'b0}.
  - item+1. If item == NUM_FOOD+NUM_ANTS-1, go to DONE; else go to WAIT.
- DONE: busy=0. done=1 unless error=1. Go to IDLE (the done/error level is held).
- busy: high in every state except IDLE and DONE.
- Write rule: mem_we is high only in CLEAR, NEST and WRITE; at most one write per cycle.
- Occupancy rule: no cell ever receives two non-empty writes during one build.

Optional Feature:
- Macro: WORLD_SEEDER_STATS_EN.
- Defined: extra output port total_retries, out, 16 bits.
  - Counts all occupied-cell draws in the current build and saturates at 16'hFFFF.
  - Cleared on an accepted start and on reset.
- Not defined: no port and no counter logic.

Test Plan:
1. reset_n=0 for 2 cycles, then release; start with seed=32'h1 -> ld_seed high for exactly 1 cycle with rand_seed=32'h1; 4096 CLEAR writes of 8'h00; one write of 8'hC0 at addr 12'h820.
2. Full build using a behavioural LFSR plus a 4096x8 RAM model -> done=1, error=0; RAM holds exactly 16 food cells with payload!=0, 8 ant cells 8'h80 and 1 nest cell; no duplicate addresses.
3. start with seed=32'hFFFF_FFFF -> rand_seed=32'hFFFF_FFFE.
4. RAM model returns 8'h40 for every read after NEST -> error=1 and done=0 after 255 retries; no WRITE-state writes occur.
5. Pulse start while busy=1 -> ignored; completion timing is unchanged. Assert reset_n=0 mid-WAIT -> next cycle busy=0, mem_we=0, state IDLE.
6. With WORLD_SEEDER_STATS_EN defined and the RAM returning occupied for exactly 3 draws -> total_retries=3 at done.

Source files
------------

// File: rtl/world_seeder.sv
// world_seeder: builds the initial world for the ant simulation.
//
// On an accepted start the block loads the seed into the downstream LFSR, clears the
// whole grid RAM, writes the nest at the grid centre, then places NUM_FOOD food piles
// and NUM_ANTS ants at random empty cells using rejection sampling. Completion is
// reported as a done or error level back to the NIOS-II.
//
// Optional build macro: WORLD_SEEDER_STATS_EN adds the total_retries output, a saturating
// count of occupied-cell draws in the current build.
//
// Ports:
//   rand_clk      in   sole clock (shared with the LFSR)
//   reset_n       in   synchronous active-low reset
//   start         in   one-cycle build request (honoured only when idle)
//   seed[31:0]    in   LFSR seed, sampled on an accepted start
//   rand_value    in   current LFSR output
//   ld_seed       out  LFSR load strobe
//   rand_seed     out  value loaded into the LFSR
//   mem_addr      out  grid RAM address, {y,x}
//   mem_wdata     out  grid RAM write data ([7:6] type, [5:0] payload)
//   mem_we        out  grid RAM write enable
//   mem_rdata     in   grid RAM read data, valid one cycle after mem_addr
//   busy          out  build in progress
//   done          out  level, build completed successfully
//   error         out  level, build aborted after MAX_RETRY occupied draws
//   total_retries out  (WORLD_SEEDER_STATS_EN only) occupied draws this build
module world_seeder #(
  parameter int unsigned X_BITS    = 6,
  parameter int unsigned Y_BITS    = 6,
  parameter int unsigned NUM_FOOD  = 16,
  parameter int unsigned NUM_ANTS  = 8,
  parameter int unsigned STRIDE    = 32,
  parameter int unsigned MAX_RETRY = 255
) (
  input  logic                     rand_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [31:0]              seed,
  input  logic [31:0]              rand_value,
  output logic                     ld_seed,
  output logic [31:0]              rand_seed,
  output logic [X_BITS+Y_BITS-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  input  logic [7:0]               mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error
`ifdef WORLD_SEEDER_STATS_EN
  ,
  output logic [15:0]              total_retries
`endif
);

  localparam int unsigned AW       = X_BITS + Y_BITS;
  localparam int unsigned NumItems = NUM_FOOD + NUM_ANTS;
  localparam int unsigned ItemW    = $clog2(NumItems + 1);
  localparam int unsigned RetryW   = $clog2(MAX_RETRY + 2);
  localparam int unsigned WaitW    = $clog2(STRIDE + 1);

  // Nest sits at x = 2**(X_BITS-1), y = 2**(Y_BITS-1).
  localparam logic [AW-1:0] NestAddr = AW'((1 << (AW - 1)) | (1 << (X_BITS - 1)));

  typedef enum logic [3:0] {
    StIdle,
    StSeed,
    StClear,
    StNest,
    StWait,
    StDraw,
    StCheck,
    StWrite,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         seed_q, seed_d;
  logic [AW-1:0]       clr_q, clr_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [ItemW-1:0]    item_q, item_d;
  logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
  logic [AW-1:0]       cell_q, cell_d;
  logic [5:0]          amt_q, amt_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef WORLD_SEEDER_STATS_EN
  logic [15:0]         stat_q, stat_d;
`endif

  // Only the coordinate and amount fields of rand_value, and the type field of
  // mem_rdata, carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{rand_value, mem_rdata};

  always_ff @(posedge rand_clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      seed_q  <= '0;
      clr_q   <= '0;
      wait_q  <= '0;
      item_q  <= '0;
      retry_q <= '0;
      cell_q  <= '0;
      amt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef WORLD_SEEDER_STATS_EN
      stat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      item_q  <= item_d;
      retry_q <= retry_d;
      cell_q  <= cell_d;
      amt_q   <= amt_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef WORLD_SEEDER_STATS_EN
      stat_q  <= stat_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    clr_d     = clr_q;
    wait_d    = wait_q;
    item_d    = item_q;
    retry_d   = retry_q;
    cell_d    = cell_q;
    amt_d     = amt_q;
    done_d    = done_q;
    error_d   = error_q;
`ifdef WORLD_SEEDER_STATS_EN
    stat_d    = stat_q;
`endif
    retry_inc = retry_q + 1'b1;
    ld_seed   = 1'b0;
    rand_seed = 32'h0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          seed_d  = seed;
`ifdef WORLD_SEEDER_STATS_EN
          stat_d  = '0;
`endif
          state_d = StSeed;
        end
      end
      StSeed: begin
        ld_seed = 1'b1;
        // All-ones is the lock-up state of the XNOR LFSR.
        rand_seed = (seed_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFE : seed_q;
        clr_d     = '0;
        state_d   = StClear;
      end
      StClear: begin
        mem_we   = 1'b1;
        mem_addr = clr_q;
        clr_d    = clr_q + 1'b1;
        if (clr_q == '1) state_d = StNest;
      end
      StNest: begin
        mem_we    = 1'b1;
        mem_addr  = NestAddr;
        mem_wdata = 8'hC0;
        item_d    = '0;
        retry_d   = '0;
        wait_d    = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (wait_q == WaitW'(STRIDE - 1)) begin
          wait_d  = '0;
          state_d = StDraw;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDraw: begin
        // Address is driven straight from the LFSR so read data lands in StCheck.
        mem_addr = rand_value[AW-1:0];
        cell_d   = rand_value[AW-1:0];
        amt_d    = rand_value[31:26] | 6'd1;
        state_d  = StCheck;
      end
      StCheck: begin
        mem_addr = cell_q;
        if (mem_rdata[7:6] == 2'b00) begin
          retry_d = '0;
          state_d = StWrite;
        end else begin
          retry_d = retry_inc;
`ifdef WORLD_SEEDER_STATS_EN
          if (stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
`endif
          if (retry_inc == RetryW'(MAX_RETRY)) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_addr  = cell_q;
        mem_wdata = (item_q < ItemW'(NUM_FOOD)) ? {2'b01, amt_q} : 8'h80;
        item_d    = item_q + 1'b1;
        if (item_q == ItemW'(NumItems - 1)) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy  = (state_q != StIdle) && (state_q != StDone);
  assign done  = done_q;
  assign error = error_q;
`ifdef WORLD_SEEDER_STATS_EN
  assign total_retries = stat_q;
`endif

endmodule

// File: tb/tb_world_seeder.sv
// Directed bench for world_seeder: drives a behavioural XNOR LFSR or a scripted random
// source, models a 4096x8 grid RAM with one-cycle read latency, and checks reset state,
// seeding, clear/nest writes, placement results, retry abort, ignored starts, mid-build
// reset and (when WORLD_SEEDER_STATS_EN is defined) the retry statistic.
module tb_world_seeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] seed;
  logic [31:0] rand_value;
  logic        ld_seed;
  logic [31:0] rand_seed;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic        error;
`ifdef WORLD_SEEDER_STATS_EN
  logic [15:0] total_retries;
`endif

  always #5 clk = ~clk;

  world_seeder dut (
    .rand_clk      (clk),
    .reset_n       (reset_n),
    .start         (start),
    .seed          (seed),
    .rand_value    (rand_value),
    .ld_seed       (ld_seed),
    .rand_seed     (rand_seed),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .error         (error)
`ifdef WORLD_SEEDER_STATS_EN
    ,
    .total_retries (total_retries)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Cycles since the last accepted start (0 in the SEED cycle).
  int tcnt = 0;
  always @(posedge clk) begin
    if (start && !busy) tcnt <= 0;
    else tcnt <= tcnt + 1;
  end

  // Behavioural XNOR LFSR.
  logic [31:0] lfsr = 32'h0;
  always @(posedge clk) begin
    if (ld_seed) lfsr <= rand_seed;
    else lfsr <= {lfsr[30:0], ~(lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0])};
  end

  // mode 0: LFSR. mode 1: scripted; nest coordinates until nest_need draws of the nest
  // cell have been seen, then {amt=4, cell=tcnt[11:0]}.
  int mode = 0;
  int nest_need = 0;
  int nest_draws = 0;
  assign rand_value = (mode == 0) ? lfsr :
                      (nest_draws < nest_need) ? {6'd4, 14'd0, 12'h820} :
                      {6'd4, 14'd0, tcnt[11:0]};

  // Grid RAM model with registered read; flags any non-empty write to a non-empty cell.
  logic [7:0] ram [0:4095];
  logic       force_occ = 1'b0;
  int         occ_viol = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_wdata != 8'h00 && ram[mem_addr] != 8'h00) occ_viol++;
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= force_occ ? 8'h40 : ram[mem_addr];
  end

  // Cumulative write/strobe monitor.
  int          n_ld = 0, n_clr = 0, clr_bad = 0, n_nest = 0, n_item = 0;
  logic [31:0] last_seed = 32'h0;
  logic [11:0] clr_next = 12'h0;
  logic [11:0] nest_addr = 12'h0;
  logic [11:0] prev_addr = 12'h0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (ld_seed) begin
      n_ld++;
      last_seed = rand_seed;
    end
    if (mem_we) begin
      if (mem_wdata == 8'h00) begin
        if (mem_addr != clr_next) clr_bad++;
        clr_next = mem_addr + 12'd1;
        n_clr++;
      end else if (mem_wdata == 8'hC0) begin
        n_nest++;
        nest_addr = mem_addr;
      end else begin
        n_item++;
      end
    end
    // Second consecutive read cycle at the nest cell = CHECK of a nest draw.
    if (!mem_we && !prev_we && mem_addr == 12'h820 && prev_addr == 12'h820) nest_draws++;
    prev_addr = mem_addr;
    prev_we   = mem_we;
  end

  int b_ld, b_clr, b_clrbad, b_nest, b_item, b_occ, b_nd;

  task automatic snap();
    b_ld = n_ld; b_clr = n_clr; b_clrbad = clr_bad; b_nest = n_nest;
    b_item = n_item; b_occ = occ_viol; b_nd = nest_draws;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int dur);
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    dur = tcnt;
  endtask

  initial begin
    int dur, n_food, n_ant, n_nestc, n_empty, n;
    reset_n = 1'b0;
    start   = 1'b0;
    seed    = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ld_seed", {31'd0, ld_seed}, 32'd0);
    chk("rst_rand_seed", rand_seed, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset_n = 1'b1;

    // Full build with the LFSR, seed 1.
    snap();
    mode = 0;
    do_start(32'h1);
    wait_idle("b1", dur);
    chk("b1_ld_count", n_ld - b_ld, 1);
    chk("b1_rand_seed", last_seed, 32'h1);
    chk("b1_clear_writes", n_clr - b_clr, 4096);
    chk("b1_clear_order", clr_bad - b_clrbad, 0);
    chk("b1_nest_writes", n_nest - b_nest, 1);
    chk("b1_nest_addr", {20'd0, nest_addr}, 32'h820);
    chk("b1_item_writes", n_item - b_item, 24);
    chk("b1_overwrites", occ_viol - b_occ, 0);
    chk("b1_done", {31'd0, done}, 32'd1);
    chk("b1_error", {31'd0, error}, 32'd0);
    n_food = 0; n_ant = 0; n_nestc = 0; n_empty = 0;
    for (int i = 0; i < 4096; i++) begin
      if (ram[i][7:6] == 2'b01 && ram[i][5:0] != 6'd0) n_food++;
      else if (ram[i] == 8'h80) n_ant++;
      else if (ram[i] == 8'hC0) n_nestc++;
      else if (ram[i] == 8'h00) n_empty++;
    end
    chk("b1_food_cells", n_food, 16);
    chk("b1_ant_cells", n_ant, 8);
    chk("b1_nest_cells", n_nestc, 1);
    chk("b1_empty_cells", n_empty, 4096 - 25);
    chk("b1_nest_cell", {24'd0, ram[12'h820]}, 32'hC0);

    // Lock-up seed substitution; scripted draws never collide, so timing is fixed.
    snap();
    mode = 1;
    nest_need = nest_draws;
    do_start(32'hFFFF_FFFF);
    wait_idle("b2", dur);
    chk("b2_ld_count", n_ld - b_ld, 1);
    chk("b2_rand_seed", last_seed, 32'hFFFF_FFFE);
    chk("b2_duration", dur, 4938);
    chk("b2_done", {31'd0, done}, 32'd1);

    // Every read occupied: abort after 255 draws, no item writes.
    snap();
    force_occ = 1'b1;
    do_start(32'h2);
    wait_idle("b3", dur);
    chk("b3_error", {31'd0, error}, 32'd1);
    chk("b3_done", {31'd0, done}, 32'd0);
    chk("b3_duration", dur, 12768);
    chk("b3_item_writes", n_item - b_item, 0);
`ifdef WORLD_SEEDER_STATS_EN
    chk("b3_total_retries", {16'd0, total_retries}, 32'd255);
`endif
    force_occ = 1'b0;

    // Start pulse while busy is ignored; completion timing and placement unchanged.
    snap();
    do_start(32'h3);
    repeat (200) @(negedge clk);
    chk("b4_busy_mid", {31'd0, busy}, 32'd1);
    seed  = 32'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("b4", dur);
    chk("b4_duration", dur, 4938);
    chk("b4_ld_count", n_ld - b_ld, 1);
    chk("b4_done", {31'd0, done}, 32'd1);
    chk("b4_error_cleared", {31'd0, error}, 32'd0);
    chk("b4_item_writes", n_item - b_item, 24);
    chk("b4_first_food", {24'd0, ram[34]}, 32'h45);
    chk("b4_last_food", {24'd0, ram[34 + 35 * 15]}, 32'h45);
    chk("b4_first_ant", {24'd0, ram[34 + 35 * 16]}, 32'h80);
    chk("b4_last_ant", {24'd0, ram[34 + 35 * 23]}, 32'h80);

    // Reset in the middle of WAIT.
    do_start(32'h4);
    n = 0;
    while (tcnt != 4100 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("b5_reached_wait", tcnt, 4100);
    reset_n = 1'b0;
    @(negedge clk);
    chk("b5_busy", {31'd0, busy}, 32'd0);
    chk("b5_mem_we", {31'd0, mem_we}, 32'd0);
    chk("b5_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("b5_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("b5_stays_idle", {31'd0, busy}, 32'd0);

    // Exactly three occupied draws (nest cell), then clean placement.
    snap();
    nest_need = nest_draws + 3;
    do_start(32'h5);
    wait_idle("b6", dur);
    chk("b6_nest_draws", nest_draws - b_nd, 3);
    chk("b6_duration", dur, 5040);
    chk("b6_done", {31'd0, done}, 32'd1);
    chk("b6_error", {31'd0, error}, 32'd0);
    chk("b6_item_writes", n_item - b_item, 24);
    chk("b6_overwrites", occ_viol - b_occ, 0);
`ifdef WORLD_SEEDER_STATS_EN
    chk("b6_total_retries", {16'd0, total_retries}, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
